// File: rtl/servile_rr_pick.sv
// Round-robin winner select: first set request searching upward from last+1, wrapping.
// Purely combinational; vld_o is low when no request is set.
module servile_rr_pick #(
  parameter int NUM = 2
) (
  input  logic [NUM-1:0]         req_i,
  input  logic [$clog2(NUM)-1:0] last_i,
  output logic [$clog2(NUM)-1:0] win_o,
  output logic                   vld_o
);

  localparam int IW = $clog2(NUM);

  int idx;

  // Walk offsets from farthest to nearest so the nearest set request overwrites.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int off = NUM; off >= 1; off--) begin
      idx = int'(last_i) + off;
      if (idx >= NUM) idx = idx - NUM;
      if (req_i[idx]) begin
        vld_o = 1'b1;
        win_o = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/servile_wb_rr_arbiter.sv
// Round-robin arbiter of NUM classic Wishbone requesters onto one memory port.
// Grant registered in IDLE; memory ack is passed back combinationally; optional timeout.
module servile_wb_rr_arbiter #(
  parameter int NUM     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM*32-1:0] i_wb_req_adr,
  input  logic [NUM*32-1:0] i_wb_req_dat,
  input  logic [NUM*4-1:0]  i_wb_req_sel,
  input  logic [NUM-1:0]    i_wb_req_we,
  input  logic [NUM-1:0]    i_wb_req_stb,
  output logic [31:0]       o_wb_req_rdt,
  output logic [NUM-1:0]    o_wb_req_ack,
  output logic [31:0]       o_wb_mem_adr,
  output logic [31:0]       o_wb_mem_dat,
  output logic [3:0]        o_wb_mem_sel,
  output logic              o_wb_mem_we,
  output logic              o_wb_mem_stb,
  input  logic [31:0]       i_wb_mem_rdt,
  input  logic              i_wb_mem_ack,
  output logic              o_timeout
);

  localparam int IW = $clog2(NUM);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [IW-1:0] pick_win;
  logic          pick_vld;
  logic          busy, stb_g, ack_acc, tmo_hit, done;

  servile_rr_pick #(.NUM(NUM)) u_pick (
    .req_i  (i_wb_req_stb),
    .last_i (last_q),
    .win_o  (pick_win),
    .vld_o  (pick_vld)
  );

  assign busy    = (state_q == S_BUSY);
  assign stb_g   = i_wb_req_stb[grant_q];
  assign ack_acc = busy && i_wb_mem_ack;
  // A memory ack in the final cycle wins over the timeout.
  assign tmo_hit = (TIMEOUT > 0) && busy && stb_g && !i_wb_mem_ack
                   && (cnt_q == CW'(TIMEOUT - 1));
  assign done    = ack_acc || tmo_hit || (busy && !stb_g);

  assign o_wb_mem_adr = i_wb_req_adr[grant_q*32 +: 32];
  assign o_wb_mem_dat = i_wb_req_dat[grant_q*32 +: 32];
  assign o_wb_mem_sel = i_wb_req_sel[grant_q*4 +: 4];
  assign o_wb_mem_we  = i_wb_req_we[grant_q];
  assign o_wb_mem_stb = busy && stb_g && !tmo_hit && !i_rst;
  assign o_timeout    = tmo_hit && !i_rst;
  assign o_wb_req_rdt = tmo_hit ? 32'h0 : i_wb_mem_rdt;

  always_comb begin
    o_wb_req_ack = '0;
    if ((ack_acc || tmo_hit) && !i_rst) o_wb_req_ack[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (pick_vld) begin
        state_d = S_BUSY;
        grant_d = pick_win;
        cnt_d   = '0;
      end
    end else if (done) begin
      state_d = S_IDLE;
      last_d  = grant_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/servile_wb_rr_arbiter.md
SERVILE_WB_RR_ARBITER -- requirements
Module: servile_wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM, default 2, number of Wishbone requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for memory ack; 0 disables timeout.
REQ-003 SHALL have i_clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have i_rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have i_wb_req_adr  input  NUM*32  requester addresses; requester k at bits [32k+31:32k].
REQ-006 SHALL have i_wb_req_dat  input  NUM*32  requester write data, same packing.
REQ-007 SHALL have i_wb_req_sel  input  NUM*4  requester byte selects.
REQ-008 SHALL have i_wb_req_we  input  NUM  requester write enables.
REQ-009 SHALL have i_wb_req_stb  input  NUM  requester strobes (stb=cyc, classic Wishbone).
REQ-010 SHALL have o_wb_req_rdt  output  32  read data, broadcast to all requesters.
REQ-011 SHALL have o_wb_req_ack  output  NUM  per-requester ack, one-hot or zero.
REQ-012 SHALL have o_wb_mem_adr/o_wb_mem_dat  output  32 each  granted requester address/data.
REQ-013 SHALL have o_wb_mem_sel  output  4, o_wb_mem_we  output  1, o_wb_mem_stb  output  1.
REQ-014 SHALL have i_wb_mem_rdt  input  32, i_wb_mem_ack  input  1  memory response.
REQ-015 SHALL have o_timeout  output  1  one-cycle pulse when a transfer is terminated by timeout.

Function
REQ-016 SHALL implement FSM with states IDLE and BUSY.
REQ-017 IDLE: if any i_wb_req_stb set, SHALL register grant = first set requester searching upward from (last+1) mod NUM, wrapping; go BUSY next cycle.
REQ-018 IDLE: o_wb_mem_stb SHALL be 0 and o_wb_req_ack all 0.
REQ-019 BUSY: o_wb_mem_adr/dat/sel/we SHALL be the granted requester's inputs; o_wb_mem_stb = granted stb.
REQ-020 BUSY with i_wb_mem_ack=1: o_wb_req_ack[grant] SHALL be 1 that same cycle (combinational); o_wb_req_rdt = i_wb_mem_rdt; last <= grant; next state IDLE.
REQ-021 Minimum latency: stb at cycle 0 -> o_wb_mem_stb at cycle 1 -> ack to requester at cycle 1 if memory acks same cycle.
REQ-022 BUSY with granted stb=0 and no ack (requester abort): SHALL return to IDLE next cycle, no ack, last <= grant.
REQ-023 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-024 TIMEOUT>0 and counter == TIMEOUT-1 without ack: SHALL assert o_wb_req_ack[grant], force o_wb_req_rdt=0, pulse o_timeout, deassert o_wb_mem_stb that cycle, go IDLE.
REQ-025 Simultaneous mem ack and timeout cycle: ack SHALL take precedence; rdt from memory, o_timeout=0.
REQ-026 Grant SHALL not change while BUSY regardless of other stb activity.
REQ-027 Requesters with stb held continuously SHALL be served in strict rotation; no requester waits more than NUM-1 transfers.
REQ-028 o_wb_req_rdt SHALL equal i_wb_mem_rdt whenever no timeout is being signalled.

Reset
REQ-029 On i_rst: state=IDLE, last=NUM-1 (requester 0 wins first), counter=0, grant=0.
REQ-030 During/after reset cycle: o_wb_mem_stb=0, o_wb_req_ack=0, o_timeout=0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no ack to the requester.

Structure
REQ-032 Counter width $clog2(TIMEOUT+1) and the state encoding SHALL be local parameters; no shared package needed.
REQ-033 Round-robin priority selection SHALL be a sub-module servile_rr_pick (NUM-bit request, last index in, winner index and valid out), combinational.

Verification
REQ-034 NUM=2, both stb high from reset, memory acks 1 cycle after stb -> grants alternate 0,1,0,1; each ack one-hot.
REQ-035 Only req1 stb, adr=0x00001000, mem ack same cycle, rdt=0xDEADBEEF -> o_wb_mem_stb cycle 1, o_wb_req_ack=2'b10 cycle 1, rdt 0xDEADBEEF.
REQ-036 TIMEOUT=4, memory never acks -> ack to requester and o_timeout pulse on 4th BUSY cycle, rdt=0, o_wb_mem_stb low that cycle.
REQ-037 TIMEOUT=4, mem ack on 4th BUSY cycle -> normal ack, o_timeout=0, rdt from memory.
REQ-038 Requester 0 drops stb in BUSY before ack -> no ack, IDLE next cycle, requester 1 granted next.
REQ-039 Assert i_rst in BUSY -> next cycle IDLE, no ack, o_wb_mem_stb=0; requester 0 wins first post-reset grant.
